// File: rtl/inv_mix_cols_seq.sv
// Sequential AES InvMixColumns: one column per clock through a shared GF(2^8) unit.
// Define INV_MIX_COLS_ALL_COLS_EN to transform all four columns in a single CALC cycle.
module inv_mix_cols_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] Din,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] Dout,
    output logic         out_valid,
    input  logic         out_ready
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [127:0] r_work;
    logic [127:0] w_work_calc;
    logic         w_calc_last;
    logic         w_accept;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Column bits [31:24] are row 0, [7:0] are row 3.
    function automatic logic [31:0] inv_col(input logic [31:0] col);
        logic [3:0][7:0] r, x2, x4, x8, m9, mb, md, me;
        for (int i = 0; i < 4; i++) begin
            r[i]  = col[8*(3-i) +: 8];
            x2[i] = xtime(r[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ r[i];
            mb[i] = x8[i] ^ x2[i] ^ r[i];
            md[i] = x8[i] ^ x4[i] ^ r[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    assign w_accept = in_valid & in_ready;

`ifdef INV_MIX_COLS_ALL_COLS_EN
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col_unit
            assign w_work_calc[32*gi +: 32] = inv_col(r_work[32*gi +: 32]);
        end
    endgenerate
    assign w_calc_last = 1'b1;
`else
    logic [1:0]  r_col_cnt;
    logic [31:0] w_col_in;
    logic [31:0] w_col_out;

    always_comb begin
        w_col_in = r_work[31:0];
        case (r_col_cnt)
            2'd0:    w_col_in = r_work[31:0];
            2'd1:    w_col_in = r_work[63:32];
            2'd2:    w_col_in = r_work[95:64];
            default: w_col_in = r_work[127:96];
        endcase
    end

    assign w_col_out = inv_col(w_col_in);

    // Only the column selected by col_cnt is replaced; the others pass through.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col_merge
            assign w_work_calc[32*gi +: 32] = (r_col_cnt == 2'(gi)) ? w_col_out
                                                                    : r_work[32*gi +: 32];
        end
    endgenerate

    assign w_calc_last = (r_col_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_cnt <= 2'd0;
        end else if (w_accept) begin
            r_col_cnt <= 2'd0;
        end else if (r_state == S_CALC) begin
            r_col_cnt <= r_col_cnt + 2'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = S_CALC;
            S_CALC:  if (w_calc_last) w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = in_valid ? S_CALC : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // A completing output handshake frees the block for a back-to-back accept.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: in_ready = 1'b1;
            S_DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work <= '0;
        end else if (w_accept) begin
            r_work <= Din;
        end else if (r_state == S_CALC) begin
            r_work <= w_work_calc;
        end
    end

    assign Dout = r_work;

endmodule

// File: tb/tb_inv_mix_cols_seq.sv
// Self-checking bench for inv_mix_cols_seq: vector table, handshake corner cases,
// and randomized streaming against a generic GF(2^8) matrix model.
module tb_inv_mix_cols_seq;
`ifdef INV_MIX_COLS_ALL_COLS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 4;
`endif
    localparam int RST_DLY = (LAT > 1) ? 1 : 0;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] Din;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] Dout;
    logic         out_valid;
    logic         out_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inv_mix_cols_seq dut (
        .clk       (clk),
        .rst       (rst),
        .Din       (Din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Dout      (Dout),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1B) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    // Circulant matrix product per column; row i is byte 4c+3-i.
    function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
        logic [7:0]   base [4];
        logic [7:0]   acc;
        logic [127:0] o;
        if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(base[(j - i + 4) % 4], s[32*c + 8*(3-j) +: 8]);
                o[32*c + 8*(3-i) +: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_block(input string tag, input logic [127:0] din, input logic [127:0] exp);
        int lat;
        @(negedge clk);
        Din = din;
        in_valid = 1'b1;
        out_ready = 1'b0;
        #1;
        chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        chk({tag, "_latency"}, 128'(lat), 128'(LAT));
        chk({tag, "_dout"}, Dout, exp);
        @(negedge clk);
        chk({tag, "_dout_held"}, Dout, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_released"}, 128'(out_valid), 128'(0));
    endtask

    task automatic run_stream(input string tag, input int nblk, input bit random_hs);
        logic [127:0] q[$];
        logic [127:0] cur, orig, held;
        bit hold_chk;
        int sent, got, cyc, last_out;
        hold_chk = 1'b0;
        sent = 0;
        got = 0;
        cyc = 0;
        last_out = -1;
        held = '0;
        cur = rnd128();
        while (got < nblk && cyc < nblk * 20 + 100) begin
            @(negedge clk);
            cyc++;
            out_ready = random_hs ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_valid = (sent < nblk) && (random_hs ? ($urandom_range(0, 3) != 0) : 1'b1);
            Din = cur;
            #1;
            if (hold_chk) begin
                chk({tag, "_hold_valid"}, 128'(out_valid), 128'(1));
                chk({tag, "_hold_data"}, Dout, held);
                hold_chk = 1'b0;
            end
            if (out_valid && out_ready) begin
                orig = (q.size() > 0) ? q.pop_front() : 'x;
                chk({tag, "_data"}, Dout, mix(orig, 1'b1));
                chk({tag, "_round_trip"}, mix(Dout, 1'b0), orig);
                if (!random_hs && last_out >= 0)
                    chk({tag, "_interval"}, 128'(cyc - last_out), 128'(LAT + 1));
                last_out = cyc;
                got++;
            end else if (out_valid) begin
                held = Dout;
                hold_chk = 1'b1;
            end
            if (in_valid && in_ready) begin
                q.push_back(cur);
                sent++;
                cur = rnd128();
            end
        end
        if (got < nblk) chk({tag, "_timeout"}, 128'(got), 128'(nblk));
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk({tag, "_drained"}, 128'(out_valid), 128'(0));
    endtask

    initial begin
        logic [127:0] held, nd, d0;
        int lat;

        vecs[0] = '{din:  {32'hc6c6c6c6, 32'h01010101, 32'h9fdc589d, 32'h8e4da1bc},
                    dout: {32'hc6c6c6c6, 32'h01010101, 32'hf20a225c, 32'hdb135345}};
        vecs[1] = '{din:  {32'hd5d5d7d6, 32'h4d7ebdf8, 32'h8e4da1bc, 32'h01010101},
                    dout: {32'hd4d4d4d5, 32'h2d26314c, 32'hdb135345, 32'h01010101}};
        vecs[2] = '{din: 128'h0, dout: 128'h0};
        vecs[3] = '{din: {128{1'b1}}, dout: {128{1'b1}}};

        // Reset with in_valid asserted: nothing may be accepted.
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b0;
        Din = rnd128();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_dout", Dout, 128'h0);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        repeat (6) @(negedge clk);
        chk("rst_no_accept_valid", 128'(out_valid), 128'(0));
        chk("rst_no_accept_dout", Dout, 128'h0);

        for (int v = 0; v < 4; v++)
            do_block($sformatf("vec%0d", v), vecs[v].din, vecs[v].dout);

        // Backpressure: DONE held for 10 cycles with a pending input.
        @(negedge clk);
        Din = vecs[0].din;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_latency", 128'(lat), 128'(LAT));
        held = Dout;
        Din = rnd128();
        in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_stable", Dout, held);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            chk("bp_valid", 128'(out_valid), 128'(1));
        end
        nd = rnd128();
        Din = nd;
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("bp_b2b_calc", 128'(out_valid), 128'(0));
        wait_valid(lat);
        chk("bp_b2b_latency", 128'(lat), 128'(LAT));
        chk("bp_b2b_dout", Dout, mix(nd, 1'b1));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during the second CALC cycle abandons the block.
        d0 = rnd128();
        @(negedge clk);
        Din = d0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (RST_DLY) @(negedge clk);
        chk("midrst_pre_valid", 128'(out_valid), 128'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_idle", 128'(in_ready), 128'(1));
        chk("midrst_dout", Dout, 128'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("midrst_no_valid", 128'(out_valid), 128'(0));
        end
        do_block("midrst_next", vecs[1].din, vecs[1].dout);

        run_stream("stream", 1000, 1'b0);
        run_stream("rand_hs", 500, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
